dp_ram_be: RTL and testbench
============================

DP_RAM_BE -- requirements
Module: dp_ram_be

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8, and NB = DATA_WIDTH/8 byte lanes.
REQ-002 Parameter ADDR_WIDTH, default 10: address width; DEPTH = 2^ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 1: read latency in cycles, legal values 1 or 2; any other value SHALL fail elaboration.
REQ-004 Parameter RDW_MODE, default 0: same-port read-during-write behaviour, 0 = READ_FIRST, 1 = WRITE_FIRST.
REQ-005 Parameter INIT_VALUE, default 0: word value written by the init sweep.
REQ-006 clk  input  1  sole clock; all logic on posedge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 init_req  input  1  one-cycle pulse requesting a memory clear.
REQ-009 busy  output  1  high while the init sweep runs.
REQ-010 en_a, en_b  input  1  port access enable.
REQ-011 we_a, we_b  input  NB  per-byte write enables, valid only when en_x=1.
REQ-012 addr_a, addr_b  input  ADDR_WIDTH  word address.
REQ-013 din_a, din_b  input  DATA_WIDTH  write data.
REQ-014 dout_a, dout_b  output  DATA_WIDTH  read data.
REQ-015 dout_valid_a, dout_valid_b  output  1  dout_x carries the read result for the access issued READ_LATENCY cycles earlier.
REQ-016 collision  output  1  one-cycle pulse flagging a write-write collision.
REQ-017 collision_cnt  output  16  saturating count of collisions.

Function
REQ-018 FSM states: INIT and RUN; reset forces INIT with sweep address 0.
REQ-019 INIT: write INIT_VALUE to one word per cycle, address 0 to DEPTH-1; after the write to DEPTH-1, go to RUN on the next edge; the sweep takes DEPTH cycles.
REQ-020 busy SHALL be 1 exactly while in INIT.
REQ-021 In INIT, en_a/en_b are ignored: no port writes, and dout_valid_x = 0.
REQ-022 init_req=1 in RUN: enter INIT at address 0 on the next edge; any port access in that same cycle still completes normally.
REQ-023 init_req in INIT is ignored; the sweep does not restart.
REQ-024 A port access occurs when en_x=1 in RUN; every access is also a read of addr_x.
REQ-025 Writes are byte-granular: lane i is updated from din_x[8i+7:8i] iff we_x[i]=1; other lanes keep their value.
REQ-026 Read data appears on dout_x with dout_valid_x=1 exactly READ_LATENCY cycles after the access edge.
REQ-027 When READ_LATENCY=2, the second register stage is a pipeline stage: back-to-back accesses yield back-to-back valid results.
REQ-028 dout_x holds its last value while dout_valid_x=0.
REQ-029 Same-port read-during-write, READ_FIRST: the read returns the pre-write word.
REQ-030 Same-port read-during-write, WRITE_FIRST: the read returns the merged word (written lanes new, others old).
REQ-031 Cross-port, same address, one port writes and the other reads in the same cycle: the reader always gets the pre-write word, independent of RDW_MODE.
REQ-032 Both ports write the same address in the same cycle: per lane, port A's data wins where both enable the lane; lanes enabled by only one port take that port's data.
REQ-033 Collision is defined as same address, both en, and (we_a & we_b) != 0.
REQ-034 On a collision, collision SHALL pulse high on the cycle after the access edge.
REQ-035 On a collision, collision_cnt increments by 1, saturating at 0xFFFF.
REQ-036 Reads on each port return that port's own RDW view; port B's read is not affected by port A winning a lane.

Reset
REQ-037 Asserting rst_n=0 at any time, including mid-sweep or mid-pipeline, SHALL immediately clear the registered outputs and state: busy=1 (INIT), dout_a=dout_b=0, dout_valid_a=dout_valid_b=0, collision=0, collision_cnt=0, sweep address=0, pipeline valids cleared.
REQ-038 Memory array contents are not reset asynchronously; they are cleared only by the INIT sweep, which restarts at address 0 after rst_n deasserts.

Verification
REQ-039 Reset release, DEPTH=16: busy high for 16 cycles then low; every address then reads 0; en pulses issued during busy produce no dout_valid.
REQ-040 Byte enables: write 0xAABBCCDD to addr 5 with we=1111, then 0x11223344 with we=0101 -> a read of addr 5 returns 0xAA22CC44.
REQ-041 RDW: addr 3 holds 0x1; write 0x2 to addr 3 with a same-port read -> READ_FIRST returns 0x1, WRITE_FIRST returns 0x2; port B reading addr 3 in the same cycle returns 0x1.
REQ-042 Collision: A writes 0x11111111 with we=0011 and B writes 0x22222222 with we=0110 to addr 7 -> word = 0x00221111 (from 0), collision pulses once, collision_cnt=1; 70000 collisions -> collision_cnt=0xFFFF.
REQ-043 Latency 2: continuous reads of addrs 0..9 -> dout_valid is high for 10 consecutive cycles starting 2 cycles after the first access, with data in address order.
REQ-044 Mid-operation: init_req in RUN restarts the sweep; rst_n asserted mid-sweep clears all outputs asynchronously and the sweep restarts from address 0.

Source files
------------

// File: rtl/dp_ram_be.sv
// True dual-port RAM with per-byte write enables, a self-clearing init sweep,
// selectable read latency / read-during-write mode, and write-collision tracking.
module dp_ram_be #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 10,
   parameter int                    READ_LATENCY = 1,
   parameter int                    RDW_MODE     = 0,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    init_req,
   output logic                    busy,
   input  logic                    en_a,
   input  logic                    en_b,
   input  logic [DATA_WIDTH/8-1:0] we_a,
   input  logic [DATA_WIDTH/8-1:0] we_b,
   input  logic [ADDR_WIDTH-1:0]   addr_a,
   input  logic [ADDR_WIDTH-1:0]   addr_b,
   input  logic [DATA_WIDTH-1:0]   din_a,
   input  logic [DATA_WIDTH-1:0]   din_b,
   output logic [DATA_WIDTH-1:0]   dout_a,
   output logic [DATA_WIDTH-1:0]   dout_b,
   output logic                    dout_valid_a,
   output logic                    dout_valid_b,
   output logic                    collision,
   output logic [15:0]             collision_cnt
);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   generate
      if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
         $error("dp_ram_be: READ_LATENCY must be 1 or 2");
      end
      if (DATA_WIDTH % 8 != 0) begin : g_bad_width
         $error("dp_ram_be: DATA_WIDTH must be a multiple of 8");
      end
   endgenerate

   typedef enum logic {INIT, RUN} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   sweep_addr;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    acc_a, acc_b, coll_now;
   logic [DATA_WIDTH-1:0]   rd_a, rd_b;
   logic [DATA_WIDTH-1:0]   s1_data_a, s1_data_b;
   logic                    s1_valid_a, s1_valid_b;

   assign busy     = (state == INIT);
   assign acc_a    = (state == RUN) && en_a;
   assign acc_b    = (state == RUN) && en_b;
   assign coll_now = acc_a && acc_b && (addr_a == addr_b) && ((we_a & we_b) != '0);

   // Port B lanes are written first so port A overrides shared lanes on a collision.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[sweep_addr] <= INIT_VALUE;
      end else begin
         for (int i = 0; i < NB; i++) begin
            if (acc_b && we_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
            if (acc_a && we_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
         end
      end
   end

   // Each port sees only its own write in WRITE_FIRST mode; the other port reads old data.
   always_comb begin
      rd_a = mem[addr_a];
      rd_b = mem[addr_b];
      if (RDW_MODE == 1) begin
         for (int i = 0; i < NB; i++) begin
            if (we_a[i]) rd_a[8*i +: 8] = din_a[8*i +: 8];
            if (we_b[i]) rd_b[8*i +: 8] = din_b[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= INIT;
         sweep_addr    <= '0;
         s1_data_a     <= '0;
         s1_data_b     <= '0;
         s1_valid_a    <= 1'b0;
         s1_valid_b    <= 1'b0;
         dout_a        <= '0;
         dout_b        <= '0;
         dout_valid_a  <= 1'b0;
         dout_valid_b  <= 1'b0;
         collision     <= 1'b0;
         collision_cnt <= '0;
      end else begin
         case (state)
            INIT: begin
               if (sweep_addr == '1) begin
                  state      <= RUN;
                  sweep_addr <= '0;
               end else begin
                  sweep_addr <= sweep_addr + 1'b1;
               end
            end
            RUN: begin
               if (init_req) begin
                  state      <= INIT;
                  sweep_addr <= '0;
               end
            end
            default: state <= INIT;
         endcase

         s1_valid_a <= acc_a;
         s1_valid_b <= acc_b;
         if (acc_a) s1_data_a <= rd_a;
         if (acc_b) s1_data_b <= rd_b;

         if (READ_LATENCY == 1) begin
            dout_valid_a <= acc_a;
            dout_valid_b <= acc_b;
            if (acc_a) dout_a <= rd_a;
            if (acc_b) dout_b <= rd_b;
         end else begin
            dout_valid_a <= s1_valid_a;
            dout_valid_b <= s1_valid_b;
            if (s1_valid_a) dout_a <= s1_data_a;
            if (s1_valid_b) dout_b <= s1_data_b;
         end

         collision <= coll_now;
         if (coll_now && collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances (latency 1 READ_FIRST, latency 2 WRITE_FIRST)
// share one stimulus stream; a reference memory model fills per-port expected queues.
module tb_dp_ram_be;
   localparam int AW = 4;
   localparam int DW = 32;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          init_req = 1'b0;
   logic          en_a = 1'b0, en_b = 1'b0;
   logic [3:0]    we_a = '0, we_b = '0;
   logic [AW-1:0] addr_a = '0, addr_b = '0;
   logic [DW-1:0] din_a = '0, din_b = '0;

   logic          busy0, busy1, coll0, coll1;
   logic [15:0]   cnt0, cnt1;
   logic [DW-1:0] dout_a0, dout_b0, dout_a1, dout_b1;
   logic          val_a0, val_b0, val_a1, val_b1;

   dp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy0),
      .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
      .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
      .dout_a(dout_a0), .dout_b(dout_b0), .dout_valid_a(val_a0), .dout_valid_b(val_b0),
      .collision(coll0), .collision_cnt(cnt0));

   dp_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RDW_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy1),
      .en_a(en_a), .en_b(en_b), .we_a(we_a), .we_b(we_b),
      .addr_a(addr_a), .addr_b(addr_b), .din_a(din_a), .din_b(din_b),
      .dout_a(dout_a1), .dout_b(dout_b1), .dout_valid_a(val_a1), .dout_valid_b(val_b1),
      .collision(coll1), .collision_cnt(cnt1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Streams: 0 = u0 port A, 1 = u0 port B, 2 = u1 port A, 3 = u1 port B
   logic [DW-1:0] exp_q [4][$];
   int            due_q [4][$];
   logic [DW-1:0] last_s [4];
   logic [DW-1:0] dout_s [4];
   logic          val_s  [4];

   assign dout_s[0] = dout_a0;  assign val_s[0] = val_a0;
   assign dout_s[1] = dout_b0;  assign val_s[1] = val_b0;
   assign dout_s[2] = dout_a1;  assign val_s[2] = val_a1;
   assign dout_s[3] = dout_b1;  assign val_s[3] = val_b1;

   logic [DW-1:0] m_mem [DEPTH];
   int            m_init_left = 0;
   logic [15:0]   m_cnt = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         for (int s = 0; s < 4; s++) begin
            if (val_s[s]) begin
               if (exp_q[s].size() == 0) begin
                  check($sformatf("unexpected_valid_s%0d", s), 32'(val_s[s]), 32'd0);
               end else begin
                  check($sformatf("rd_data_s%0d", s), dout_s[s], exp_q[s].pop_front());
                  check($sformatf("rd_cycle_s%0d", s), 32'(cyc), 32'(due_q[s].pop_front()));
               end
               last_s[s] = dout_s[s];
            end else begin
               check($sformatf("dout_hold_s%0d", s), dout_s[s], last_s[s]);
               if (due_q[s].size() > 0 && due_q[s][0] <= cyc) begin
                  check($sformatf("valid_missing_s%0d", s), 32'(val_s[s]), 32'd1);
                  void'(exp_q[s].pop_front());
                  void'(due_q[s].pop_front());
               end
            end
         end
      end
   end

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [3:0] we);
      logic [DW-1:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // Called at posedge+2; drives one cycle of stimulus and returns at the next posedge+2.
   task automatic drive(input logic ea, input logic [3:0] wea, input logic [AW-1:0] aa,
                        input logic [DW-1:0] da, input logic eb, input logic [3:0] web,
                        input logic [AW-1:0] ab, input logic [DW-1:0] db, input logic ireq);
      logic          exp_coll;
      logic [DW-1:0] old_a, old_b;
      check("busy_u0", 32'(busy0), 32'(m_init_left > 0));
      check("busy_u1", 32'(busy1), 32'(m_init_left > 0));
      en_a = ea; we_a = wea; addr_a = aa; din_a = da;
      en_b = eb; we_b = web; addr_b = ab; din_b = db;
      init_req = ireq;
      exp_coll = 1'b0;
      if (m_init_left > 0) begin
         m_mem[DEPTH - m_init_left] = '0;
         m_init_left--;
      end else begin
         old_a = m_mem[aa];
         old_b = m_mem[ab];
         if (ea) begin
            exp_q[0].push_back(old_a);                  due_q[0].push_back(cyc + 1);
            exp_q[2].push_back(merge(old_a, da, wea));  due_q[2].push_back(cyc + 2);
         end
         if (eb) begin
            exp_q[1].push_back(old_b);                  due_q[1].push_back(cyc + 1);
            exp_q[3].push_back(merge(old_b, db, web));  due_q[3].push_back(cyc + 2);
         end
         exp_coll = ea && eb && (aa == ab) && ((wea & web) != 4'b0);
         if (eb) m_mem[ab] = merge(m_mem[ab], db, web);
         if (ea) m_mem[aa] = merge(m_mem[aa], da, wea);
         if (exp_coll && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (ireq) m_init_left = DEPTH;
      end
      @(posedge clk);
      #2;
      check("collision_u0", 32'(coll0), 32'(exp_coll));
      check("collision_u1", 32'(coll1), 32'(exp_coll));
      check("coll_cnt_u0", 32'(cnt0), 32'(m_cnt));
      check("coll_cnt_u1", 32'(cnt1), 32'(m_cnt));
      en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0; init_req = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, 0);
   endtask

   task automatic rd(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
      drive(1, 4'h0, aa, '0, 1, 4'h0, ab, '0, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en_a = 1'b0; en_b = 1'b0; init_req = 1'b0;
      #1;
      check("rst_busy_u0", 32'(busy0), 32'd1);
      check("rst_busy_u1", 32'(busy1), 32'd1);
      check("rst_dout_a0", dout_a0, 32'd0);
      check("rst_dout_b0", dout_b0, 32'd0);
      check("rst_dout_a1", dout_a1, 32'd0);
      check("rst_dout_b1", dout_b1, 32'd0);
      check("rst_valid", {28'd0, val_a0, val_b0, val_a1, val_b1}, 32'd0);
      check("rst_coll", {30'd0, coll0, coll1}, 32'd0);
      check("rst_cnt_u0", 32'(cnt0), 32'd0);
      check("rst_cnt_u1", 32'(cnt1), 32'd0);
      for (int s = 0; s < 4; s++) begin
         exp_q[s].delete();
         due_q[s].delete();
         last_s[s] = '0;
      end
      m_cnt = '0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      m_init_left = DEPTH;
   endtask

   initial begin
      for (int s = 0; s < 4; s++) last_s[s] = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      @(posedge clk);
      #2;
      do_reset();

      // Sweep with enable pulses that must be ignored, then every word reads zero.
      for (int i = 0; i < DEPTH; i++) drive(1, 4'hF, AW'(i), 32'hDEAD0000 + i, 1, 4'hF, AW'(i), 32'hBEEF, 0);
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(DEPTH - 1 - i));

      // Byte-lane merge at address 5.
      drive(1, 4'hF, 4'd5, 32'hAABBCCDD, 0, 4'h0, '0, '0, 0);
      drive(1, 4'h5, 4'd5, 32'h11223344, 0, 4'h0, '0, '0, 0);
      rd(4'd5, 4'd5);

      // Read-during-write at address 3, port B reading the same word.
      drive(1, 4'hF, 4'd3, 32'h1, 0, 4'h0, '0, '0, 0);
      drive(1, 4'hF, 4'd3, 32'h2, 1, 4'h0, 4'd3, '0, 0);
      rd(4'd3, 4'd3);

      // Lane-split write collision at address 7 (word starts at zero).
      drive(1, 4'b0011, 4'd7, 32'h11111111, 1, 4'b0110, 4'd7, 32'h22222222, 0);
      rd(4'd7, 4'd7);
      idle(2);

      for (int i = 0; i < 200; i++)
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), AW'($urandom_range(0, DEPTH - 1)), $urandom, 0);

      // Back-to-back reads of 0..9 on port A.
      for (int i = 0; i < 10; i++) drive(1, 4'h0, AW'(i), '0, 0, 4'h0, '0, '0, 0);
      idle(3);

      // init_req in RUN with a concurrent write; a second init_req mid-sweep is ignored.
      drive(1, 4'hF, 4'd9, 32'h5A5A5A5A, 1, 4'h0, 4'd9, '0, 1);
      idle(4);
      drive(0, 4'h0, '0, '0, 0, 4'h0, '0, '0, 1);
      idle(DEPTH - 5);
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(i));

      // Reset in the middle of a sweep.
      drive(1, 4'hF, 4'd2, 32'hCAFEF00D, 0, 4'h0, '0, '0, 1);
      idle(6);
      do_reset();
      for (int i = 0; i < DEPTH; i++) drive(1, 4'h0, AW'(i), '0, 1, 4'h0, AW'(i), '0, 0);
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), AW'(i));

      // Saturation of the collision counter.
      for (int i = 0; i < 70000; i++) drive(1, 4'hF, 4'd7, $urandom, 1, 4'h1, 4'd7, $urandom, 0);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
